vproc_mem_slave: RTL and testbench

- Synchronous memory-mapped bus slave that sits directly downstream of the VProc virtual processor bus port.
- Consumes Addr/WE/RD/BE/DataOut/BurstFirst/BurstLast; produces DataIn/WRAck/RDAck.
- Adds programmable wait states, single-word and burst support, and protocol-error counting.
- Serves as the default test-bench memory for VProc software.

---
 rtl/vproc_mem_pkg.sv | 27 ++
 rtl/vproc_mem_ram.sv | 26 ++
 rtl/vproc_mem_slave.sv | 161 ++++++++++++++++
 tb/tb_vproc_mem_slave.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vproc_mem_pkg.sv
// Shared types and constants for the VProc memory slave.
// These include the FSM state, read-data source, LFSR constants and counter widths.
package vproc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // DataIn selects between the reset value, the RAM word and the decode-miss pattern
    typedef enum logic [1:0] {
        DSEL_ZERO = 2'd0,
        DSEL_RAM  = 2'd1,
        DSEL_ERR  = 2'd2
    } dsel_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int ERR_CNT_W   = 16;
    localparam int BURST_CNT_W = 16;
    // Holds up to 15 fixed wait states plus 3 random ones
    localparam int WCNT_W      = 5;

endpackage

// File: rtl/vproc_mem_ram.sv
// Single-port 32-bit word RAM with per-byte write enables.
// The read port is registered and holds its value until the next read.
module vproc_mem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              we,
    input  logic              re,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge Clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/vproc_mem_slave.sv
// VProc bus memory slave with wait states, burst tracking and error counting.
// The optional VPROC_MEM_RAND_WAIT_EN macro adds 0..3 LFSR-driven extra wait states per beat.
module vproc_mem_slave
    import vproc_mem_pkg::*;
#(
    parameter int          MEM_ADDR_WIDTH = 10,
    parameter int          ADDR_LSB       = 0,
    parameter logic [31:0] BASE_ADDR      = 32'h00000000,
    parameter int          WAIT_STATES    = 0,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic [3:0]  BE,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    input  logic        BurstFirst,
    input  logic        BurstLast,
    output logic [15:0] ErrCount,
    output logic [15:0] BurstCount
);

    localparam int          HI_LSB  = ADDR_LSB + MEM_ADDR_WIDTH;
    localparam logic [31:0] HI_MASK = ~((32'h1 << HI_LSB) - 32'h1);

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [1:0] n);
        logic [ERR_CNT_W:0] s;
        s = {1'b0, a} + (ERR_CNT_W+1)'(n);
        return s[ERR_CNT_W] ? '1 : s[ERR_CNT_W-1:0];
    endfunction

    state_t              state, state_nx;
    dsel_t               dsel;
    logic [WCNT_W-1:0]   wcnt, wcnt_nx, wload;
    logic                in_burst;
    logic                accept, go_ack;

    logic [31:0] addr_p0, dout_p0;
    logic [3:0]  be_p0;
    logic        wr_p0, conf_p0, bf_p0, bl_p0;

    logic [31:0] beat_addr, beat_dout;
    logic [3:0]  beat_be;
    logic        beat_wr, beat_conf, beat_bf, beat_bl, beat_miss;
    logic [1:0]  nerr;
    logic [31:0] ram_rdata;

    assign accept = (state == IDLE) && (WE || RD);

`ifdef VPROC_MEM_RAND_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge Clk) begin
        if (!nReset) lfsr <= LFSR_SEED;
        else if (accept) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0);
    end

    assign wload = WCNT_W'(WAIT_STATES) + WCNT_W'(lfsr[1:0]);
`else
    assign wload = WCNT_W'(WAIT_STATES);
`endif

    // A zero-wait beat reaches ACK on its accept edge, so the live inputs stand in for the latch
    always_comb begin
        if (state == IDLE) begin
            beat_addr = Addr;     beat_dout = DataOut;   beat_be = BE;
            beat_wr   = WE;       beat_conf = WE && RD;
            beat_bf   = BurstFirst; beat_bl = BurstLast;
        end else begin
            beat_addr = addr_p0;  beat_dout = dout_p0;   beat_be = be_p0;
            beat_wr   = wr_p0;    beat_conf = conf_p0;
            beat_bf   = bf_p0;    beat_bl   = bl_p0;
        end
    end

    assign beat_miss = ((beat_addr ^ BASE_ADDR) & HI_MASK) != 32'h0;
    assign nerr      = 2'(beat_conf) + 2'(beat_miss) + 2'(beat_bf && in_burst);

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: if (WE || RD) begin
                wcnt_nx  = wload;
                state_nx = (wload == '0) ? ACK : WAIT;
            end
            WAIT: begin
                wcnt_nx = wcnt - 1'b1;
                if (wcnt <= WCNT_W'(1)) state_nx = ACK;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign go_ack = (state != ACK) && (state_nx == ACK);
    assign WRAck  = (state == ACK) && wr_p0;
    assign RDAck  = (state == ACK) && !wr_p0;

    always_comb begin
        case (dsel)
            DSEL_RAM: DataIn = ram_rdata;
            DSEL_ERR: DataIn = ERR_DATA;
            default:  DataIn = 32'h0;
        endcase
    end

    // ---- p0: request latch, held for the whole beat
    always_ff @(posedge Clk) begin
        if (accept) begin
            addr_p0 <= Addr;
            dout_p0 <= DataOut;
            be_p0   <= BE;
            wr_p0   <= WE;
            conf_p0 <= WE && RD;
            bf_p0   <= BurstFirst;
            bl_p0   <= BurstLast;
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state      <= IDLE;
            wcnt       <= '0;
            in_burst   <= 1'b0;
            dsel       <= DSEL_ZERO;
            ErrCount   <= '0;
            BurstCount <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (go_ack) begin
                if (!beat_wr) dsel <= beat_miss ? DSEL_ERR : DSEL_RAM;
                ErrCount <= sat_add(ErrCount, nerr);
                if (beat_bl) begin
                    in_burst   <= 1'b0;
                    BurstCount <= BurstCount + 1'b1;
                end else if (beat_bf) begin
                    in_burst <= 1'b1;
                end
            end
        end
    end

    // Writes commit and reads capture on the edge that enters ACK; reset at that edge aborts both
    vproc_mem_ram #(.ADDR_W(MEM_ADDR_WIDTH)) u_ram (
        .Clk   (Clk),
        .we    (go_ack && beat_wr && !beat_miss && nReset),
        .re    (go_ack && !beat_wr && !beat_miss && nReset),
        .be    (beat_be),
        .addr  (beat_addr[ADDR_LSB +: MEM_ADDR_WIDTH]),
        .wdata (beat_dout),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_vproc_mem_slave.sv
// Scoreboard bench for vproc_mem_slave: two instances (0 and 3 wait states), one shared master.
module tb_vproc_mem_slave;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [31:0] Addr = '0, DataOut = '0;
    logic [3:0]  BE = '0;
    logic        WE = 1'b0, RD = 1'b0, BurstFirst = 1'b0, BurstLast = 1'b0;
    logic        sel = 1'b0;

    logic [31:0] a_din, b_din, DataIn;
    logic        a_wrack, a_rdack, b_wrack, b_rdack, WRAck, RDAck;
    logic [15:0] a_err, a_bcnt, b_err, b_bcnt;
    int          wait_st;

    always #5 Clk = ~Clk;

    vproc_mem_slave #(.WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_a (
        .Clk(Clk), .nReset(nReset), .Addr(Addr), .BE(BE),
        .WE(WE && !sel), .RD(RD && !sel), .DataOut(DataOut), .DataIn(a_din),
        .WRAck(a_wrack), .RDAck(a_rdack), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
        .ErrCount(a_err), .BurstCount(a_bcnt)
    );

    vproc_mem_slave #(.WAIT_STATES(3), .BASE_ADDR(32'h1000_0000)) u_b (
        .Clk(Clk), .nReset(nReset), .Addr(Addr), .BE(BE),
        .WE(WE && sel), .RD(RD && sel), .DataOut(DataOut), .DataIn(b_din),
        .WRAck(b_wrack), .RDAck(b_rdack), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
        .ErrCount(b_err), .BurstCount(b_bcnt)
    );

    assign WRAck   = sel ? b_wrack : a_wrack;
    assign RDAck   = sel ? b_rdack : a_rdack;
    assign DataIn  = sel ? b_din : a_din;
    assign wait_st = sel ? 3 : 0;

    typedef struct {
        bit          is_wr;
        bit          chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every ack pops one expectation and checks kind, timing and read data
    always @(negedge Clk) begin
        if (WRAck || RDAck) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_ack: wr=%0b rd=%0b at cycle %0d, required no ack", WRAck, RDAck, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (WRAck != mon_e.is_wr || RDAck == mon_e.is_wr || cyc != mon_e.due ||
                    (mon_e.chk && DataIn !== mon_e.data)) begin
                    miscompares++;
                    $display("FAIL ack: wr=%0b rd=%0b cycle=%0d data=%h, required wr=%0b cycle=%0d data=%h",
                             WRAck, RDAck, cyc, DataIn, mon_e.is_wr, mon_e.due, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic beat(input logic [31:0] a, input bit we, input bit rd, input logic [3:0] be,
                        input logic [31:0] d, input bit bf, input bit bl,
                        input logic [31:0] exp_d, input bit chk);
        exp_t e;
        int   n;
        @(posedge Clk); #1;
        Addr = a; WE = we; RD = rd; BE = be; DataOut = d; BurstFirst = bf; BurstLast = bl;
        e.is_wr = we; e.chk = chk; e.data = exp_d; e.due = cyc + 1 + wait_st;
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!(WRAck || RDAck) && n < 40);
        if (!(WRAck || RDAck)) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack for addr %h after %0d cycles, required ack", a, n);
        end
        WE = 1'b0; RD = 1'b0; BurstFirst = 1'b0; BurstLast = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        beat(a, 1'b1, 1'b0, be, d, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d);
        beat(a, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0, exp_d, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst_a_acks", {31'h0, a_wrack | a_rdack}, 32'h0);
        check("rst_a_din", a_din, 32'h0);
        check("rst_a_err", {16'h0, a_err}, 32'h0);
        check("rst_a_bcnt", {16'h0, a_bcnt}, 32'h0);
        check("rst_b_din", b_din, 32'h0);
        nReset = 1'b1;

        // Instance A: no wait states, base 0
        wr(32'd5, 32'h12345678, 4'hF);
        rd(32'd5, 32'h12345678);
        wr(32'd6, 32'h0BADF00D, 4'hF);
        check("din_hold_after_write", a_din, 32'h12345678);

        for (int i = 0; i < 4; i++)
            beat(32'd16 + i, 1'b1, 1'b0, 4'hF, 32'hB000_0010 + i, i == 0, i == 3, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            rd(32'd16 + i, 32'hB000_0010 + i);
        check("burst_count", {16'h0, a_bcnt}, 32'd1);
        check("burst_err", {16'h0, a_err}, 32'd0);

        beat(32'd20, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);
        check("we_rd_err", {16'h0, a_err}, 32'd1);
        beat(32'd21, 1'b1, 1'b0, 4'hF, 32'h2121_2121, 1'b1, 1'b0, 32'h0, 1'b0);
        beat(32'd22, 1'b1, 1'b0, 4'hF, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 1'b0);
        check("double_first_err", {16'h0, a_err}, 32'd2);
        rd(32'd20, 32'hCAFEF00D);
        rd(32'd22, 32'h2222_2222);
        beat(32'd23, 1'b1, 1'b0, 4'hF, 32'h2323_2323, 1'b0, 1'b1, 32'h0, 1'b0);
        check("burst_close", {16'h0, a_bcnt}, 32'd2);
        beat(32'd24, 1'b1, 1'b0, 4'hF, 32'h2424_2424, 1'b1, 1'b1, 32'h0, 1'b0);
        check("single_beat_burst", {16'h0, a_bcnt}, 32'd3);
        check("single_beat_err", {16'h0, a_err}, 32'd2);

        // Instance B: three wait states, base 0x1000_0000
        @(posedge Clk); #1;
        sel = 1'b1;
        wr(32'h1000_0007, 32'hFFFF_FFFF, 4'hF);
        wr(32'h1000_0007, 32'hAABBCCDD, 4'b0101);
        rd(32'h1000_0007, 32'hFFBBFFDD);
        wr(32'h1000_0007, 32'h0000_0000, 4'b0000);
        rd(32'h1000_0007, 32'hFFBBFFDD);
        rd(32'h2000_0000, 32'hDEADBEEF);
        check("miss_read_err", {16'h0, b_err}, 32'd1);
        wr(32'h2000_0007, 32'h1111_1111, 4'hF);
        check("miss_write_err", {16'h0, b_err}, 32'd2);
        check("din_hold_miss", b_din, 32'hDEADBEEF);
        rd(32'h1000_0007, 32'hFFBBFFDD);
        wr(32'h1000_0009, 32'h9999_9999, 4'hF);

        // Reset two cycles into a waited write: no ack, no commit
        @(posedge Clk); #1;
        Addr = 32'h1000_0009; DataOut = 32'h5555_AAAA; BE = 4'hF; WE = 1'b1;
        @(posedge Clk);
        @(posedge Clk); #1;
        nReset = 1'b0; WE = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
        check("midrst_err", {16'h0, b_err}, 32'd0);
        check("midrst_din", b_din, 32'h0);
        check("midrst_a_bcnt", {16'h0, a_bcnt}, 32'd0);
        repeat (6) @(posedge Clk);
        rd(32'h1000_0009, 32'h9999_9999);
        rd(32'h1000_0007, 32'hFFBBFFDD);

        repeat (3) @(posedge Clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
